// File: rtl/pc_fetch_ctrl.sv
// PC register and instruction-fetch control for the IF stage.
// Applies ID-stage redirects with an optional delay slot and a one-entry skid buffer.
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter bit          DELAY_SLOT = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        branch_jump_i,
    input  logic [31:0] bj_address_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ready_i,
    input  logic [31:0] imem_rdata_i,
    output logic        if_valid_o,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_inst_o,
    output logic        flush_o,
    output logic        addr_err_o
);

    typedef enum logic {S_REQ, S_SKID} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        vld_q, vld_d;
    logic [31:0] ipc_q, ipc_d;
    logic [31:0] inst_q, inst_d;
    logic        flush_q, flush_d;
    logic        err_q, err_d;
    logic        drop_q, drop_d;
    logic        pend_q, pend_d;
    logic [31:0] pend_addr_q, pend_addr_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic [31:0] skid_inst_q, skid_inst_d;

    logic        accept;
    logic        slot_live;
    logic [31:0] target;
    logic [31:0] pc_step;

    assign accept  = branch_jump_i & vld_q & ~stall_i;
    assign target  = bj_address_i & ~32'h3;
    assign pc_step = pend_q ? pend_addr_q : pc_q + 32'd4;
    // Slot fetch is already resolved this cycle: leaving skid or completing now.
    assign slot_live = (state_q == S_SKID) | (imem_ready_i & ~drop_q);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        vld_d       = vld_q;
        ipc_d       = ipc_q;
        inst_d      = inst_q;
        flush_d     = 1'b0;
        err_d       = err_q;
        drop_d      = drop_q;
        pend_d      = pend_q;
        pend_addr_d = pend_addr_q;
        skid_pc_d   = skid_pc_q;
        skid_inst_d = skid_inst_q;

        if (!stall_i) vld_d = 1'b0;

        unique case (state_q)
            S_REQ: begin
                if (imem_ready_i) begin
                    if (drop_q) begin
                        drop_d = 1'b0;
                    end else if (!stall_i) begin
                        vld_d  = 1'b1;
                        ipc_d  = pc_q;
                        inst_d = imem_rdata_i;
                        pc_d   = pc_step;
                        pend_d = 1'b0;
                    end else begin
                        skid_pc_d   = pc_q;
                        skid_inst_d = imem_rdata_i;
                        pc_d        = pc_step;
                        pend_d      = 1'b0;
                        state_d     = S_SKID;
                    end
                end
            end
            S_SKID: begin
                if (!stall_i) begin
                    vld_d   = 1'b1;
                    ipc_d   = skid_pc_q;
                    inst_d  = skid_inst_q;
                    state_d = S_REQ;
                end
            end
        endcase

        if (accept) begin
            flush_d = 1'b1;
            if (bj_address_i[1:0] != 2'b00) err_d = 1'b1;
            if (DELAY_SLOT) begin
                if (slot_live) begin
                    pc_d   = target;
                    pend_d = 1'b0;
                end else begin
                    pend_d      = 1'b1;
                    pend_addr_d = target;
                end
            end else begin
                pc_d   = target;
                pend_d = 1'b0;
                if (slot_live) begin
                    vld_d   = 1'b0;
                    state_d = S_REQ;
                end else if (!imem_ready_i) begin
                    drop_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_REQ;
            pc_q        <= RESET_PC;
            vld_q       <= 1'b0;
            ipc_q       <= 32'h0;
            inst_q      <= 32'h0;
            flush_q     <= 1'b0;
            err_q       <= 1'b0;
            drop_q      <= 1'b0;
            pend_q      <= 1'b0;
            pend_addr_q <= 32'h0;
            skid_pc_q   <= 32'h0;
            skid_inst_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            vld_q       <= vld_d;
            ipc_q       <= ipc_d;
            inst_q      <= inst_d;
            flush_q     <= flush_d;
            err_q       <= err_d;
            drop_q      <= drop_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
            skid_pc_q   <= skid_pc_d;
            skid_inst_q <= skid_inst_d;
        end
    end

    assign imem_req_o  = (state_q == S_REQ) & ~rst;
    assign imem_addr_o = pc_q;
    assign if_valid_o  = vld_q;
    assign if_pc_o     = ipc_q;
    assign if_inst_o   = inst_q;
    assign flush_o     = flush_q;
    assign addr_err_o  = err_q;

endmodule
